// File: rtl/div_clk_arbiter.sv
// div_clk_arbiter: a shared programmable clock divider with a request/grant
// front end. The winning requester's divisor and burst length are latched at
// grant time. outclk is then produced with half period div_lat+1 for
// burst_lat full periods, and the resource is released afterwards.
//
// Build option: define DIV_CLK_ARB_STRICT_PRIO_EN to select fixed priority,
// where the lowest index wins. When it is undefined, requesters are served
// round-robin, starting the search after the last owner.
//
// state   | meaning
// IDLE    | no owner, outclk low, counters cleared, waiting for any req
// LOAD    | owner latched, counters zeroed, zero-length bursts go straight out
// RUN     | outclk toggling every div_lat+1 cycles, full periods counted
// RELEASE | grant dropped, done pulsed unless aborted, outclk low

module div_clk_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 32,
  parameter int BURST_W = 8
) (
  input  logic                       inclk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*CNT_W-1:0]   div_val,
  input  logic [NUM_REQ*BURST_W-1:0] burst_len,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic                       outclk,
  output logic                       tick
);

  localparam int OW = $clog2(NUM_REQ);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic [1:0]         state;
  logic [OW-1:0]      owner;
  logic [CNT_W-1:0]   div_lat;
  logic [CNT_W-1:0]   half_cnt;
  logic [BURST_W-1:0] burst_lat;
  logic [BURST_W-1:0] period_cnt;

  logic [OW-1:0]      win_idx;
  logic [OW-1:0]      cand;
  logic               any_req;
  logic [NUM_REQ-1:0] win_onehot;

  logic [CNT_W-1:0]   div_arr   [NUM_REQ];
  logic [BURST_W-1:0] burst_arr [NUM_REQ];

`ifndef DIV_CLK_ARB_STRICT_PRIO_EN
  logic [OW-1:0]      ptr;
`endif

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign div_arr[gi]   = div_val[gi*CNT_W +: CNT_W];
    assign burst_arr[gi] = burst_len[gi*BURST_W +: BURST_W];
  end

  assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
  assign busy       = (state != ST_IDLE);

  // Winner selection: first pending requester in search order
  always_comb begin
    win_idx = '0;
    cand    = '0;
    any_req = 1'b0;
`ifdef DIV_CLK_ARB_STRICT_PRIO_EN
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = OW'(k);
      if (req[cand]) begin
        win_idx = cand;
        any_req = 1'b1;
      end
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = OW'((int'(ptr) + k) % NUM_REQ);
      if (!any_req && req[cand]) begin
        win_idx = cand;
        any_req = 1'b1;
      end
    end
`endif
  end

  // Sequencer: grant, divider counters, outclk/tick/done generation
  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= '0;
      div_lat    <= '0;
      burst_lat  <= '0;
      half_cnt   <= '0;
      period_cnt <= '0;
      grant      <= '0;
      done       <= '0;
      outclk     <= 1'b0;
      tick       <= 1'b0;
`ifndef DIV_CLK_ARB_STRICT_PRIO_EN
      ptr        <= '0;
`endif
    end else begin
      done <= '0;
      tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          outclk     <= 1'b0;
          half_cnt   <= '0;
          period_cnt <= '0;
          if (any_req) begin
            owner     <= win_idx;
            div_lat   <= div_arr[win_idx];
            burst_lat <= burst_arr[win_idx];
            grant     <= win_onehot;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          half_cnt   <= '0;
          period_cnt <= '0;
          if (!req[owner]) begin
            grant <= '0;
            state <= ST_RELEASE;
          end else if (burst_lat == '0) begin
            grant <= '0;
            done  <= grant;
            state <= ST_RELEASE;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // a dropped request takes priority over a coincident completion
          if (!req[owner]) begin
            grant  <= '0;
            outclk <= 1'b0;
            state  <= ST_RELEASE;
          end else if (half_cnt == div_lat) begin
            half_cnt <= '0;
            outclk   <= ~outclk;
            if (!outclk) begin
              tick <= 1'b1;
            end else begin
              period_cnt <= period_cnt + 1'b1;
              if (period_cnt + 1'b1 == burst_lat) begin
                grant <= '0;
                done  <= grant;
                state <= ST_RELEASE;
              end
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        default: begin
          outclk     <= 1'b0;
          half_cnt   <= '0;
          period_cnt <= '0;
          grant      <= '0;
`ifndef DIV_CLK_ARB_STRICT_PRIO_EN
          ptr        <= (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
`endif
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
